cnt_cmd_seq: RTL

- Upstream command sequencer for the 8-bit up/down counter stage.
- Accepts queued counter commands (load, count up N, count down N, hold N) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the counter's ld_en/en/updwn/datain controls cycle-by-cycle so software-level sequences run back-to-back without per-cycle intervention.

---
 rtl/cnt_cmd_seq_if.sv | 10 +
 rtl/cnt_cmd_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cnt_cmd_seq_if.sv
// Command push channel into cnt_cmd_seq: valid/ready with 2-bit opcode and 8-bit argument.
interface cnt_cmd_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cnt_cmd_seq.sv
// Sequencer driving the 8-bit up/down counter from FIFO-queued LOAD/UP/DOWN/HOLD commands; first control one edge after accept.
// cmd_ready drops while the FIFO is full; defining CNT_CMD_SEQ_FLUSH_EN adds a synchronous flush input.
module cnt_cmd_seq_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic [AW:0]  level
);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: ;
      endcase
    end
  end
endmodule

module cnt_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef CNT_CMD_SEQ_FLUSH_EN
  input  logic         flush,
`endif
  cnt_cmd_seq_if.slave cmd,
  output logic         ld_en,
  output logic         en,
  output logic         updwn,
  output logic [7:0]   datain,
  output logic         busy,
  output logic         cmd_done,
  output logic [AW:0]  level
);
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0]  OP_LOAD  = 2'b00;
  localparam logic [1:0]  OP_UP    = 2'b01;
  localparam logic [1:0]  OP_DOWN  = 2'b10;
  localparam logic [1:0]  OP_HOLD  = 2'b11;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t     state, state_nxt;
  logic [7:0] rem, rem_nxt;
  logic [7:0] datain_nxt;
  logic       ld_en_nxt, en_nxt, updwn_nxt, done_nxt;
  logic       clr, push, pop, empty;
  logic [9:0] head_dat;
  logic [1:0] head_op;
  logic [7:0] head_arg;

`ifdef CNT_CMD_SEQ_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  assign cmd.cmd_ready     = (level != FULL_LVL);
  assign push              = cmd.cmd_valid && cmd.cmd_ready && !clr;
  assign empty             = (level == '0);
  assign {head_op, head_arg} = head_dat;
  assign busy              = (state == RUN) || !empty;

  cnt_cmd_seq_fifo #(.W(10), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .push_dat ({cmd.cmd_op, cmd.cmd_arg}),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (level)
  );

  // IDLE or the last cycle of a RUN command is a command boundary: pop the next entry with zero bubble.
  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    ld_en_nxt  = ld_en;
    en_nxt     = en;
    updwn_nxt  = updwn;
    datain_nxt = datain;
    done_nxt   = 1'b0;
    pop        = 1'b0;
    if (state == IDLE || rem == 8'd1) begin
      state_nxt = IDLE;
      ld_en_nxt = 1'b0;
      en_nxt    = 1'b0;
      if (!empty) begin
        pop      = 1'b1;
        rem_nxt  = head_arg;
        done_nxt = (head_arg <= 8'd1);
        if (head_arg > 8'd1) state_nxt = RUN;
        case (head_op)
          OP_LOAD: begin
            ld_en_nxt  = 1'b1;
            datain_nxt = head_arg;
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
          end
          OP_UP, OP_DOWN: begin
            if (head_arg != 8'd0) begin
              en_nxt    = 1'b1;
              updwn_nxt = (head_op == OP_UP);
            end
          end
          OP_HOLD: ;
        endcase
      end
    end else begin
      rem_nxt  = rem - 8'd1;
      done_nxt = (rem == 8'd2);
    end
    if (clr) begin
      state_nxt = IDLE;
      ld_en_nxt = 1'b0;
      en_nxt    = 1'b0;
      done_nxt  = 1'b0;
      pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem      <= 8'd0;
      ld_en    <= 1'b0;
      en       <= 1'b0;
      updwn    <= 1'b0;
      datain   <= 8'd0;
      cmd_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      rem      <= rem_nxt;
      ld_en    <= ld_en_nxt;
      en       <= en_nxt;
      updwn    <= updwn_nxt;
      datain   <= datain_nxt;
      cmd_done <= done_nxt;
    end
  end
endmodule
